fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, meaning the redirect target on a misaligned redirect (macro on only).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: fetch address.
REQ-007 The block SHALL have port imem_ready, input, 1 bit: memory accepts the request and returns data in the same cycle.
REQ-008 The block SHALL have port imem_rdata, input, 32 bits: fetched word, valid when imem_req and imem_ready are both high.
REQ-009 The block SHALL have port stall, input, 1 bit: downstream cannot consume instr this cycle.
REQ-010 The block SHALL have port redirect_valid, input, 1 bit: the next-PC logic has selected a taken jump or branch.
REQ-011 The block SHALL have port redirect_pc, input, 32 bits: the jump or branch target.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: instr and instr_pc are valid.
REQ-013 The block SHALL have port instr, output, 32 bits: the held instruction.
REQ-014 The block SHALL have port instr_pc, output, 32 bits: the address of instr.
REQ-015 The block SHALL have port trap, output, 1 bit: one-cycle misaligned-redirect pulse.

Function
REQ-016 The FSM SHALL have states BOOT, FETCH, HOLD and FLUSH, encoded in a registered state variable.
REQ-017 BOOT SHALL last exactly one cycle after reset release and SHALL then go to FETCH with imem_req low.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
- imem_addr SHALL be held stable while imem_req=1 and imem_ready=0.
REQ-019 FETCH with imem_ready=1 and no redirect SHALL, on the next edge:
- instr <= imem_rdata, instr_pc <= pc
- instr_valid <= 1, pc <= pc+4, state -> HOLD
REQ-020 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-021 In HOLD, imem_req SHALL be 0.
- stall=1: instr, instr_pc and instr_valid hold.
- stall=0: the instruction is consumed; next edge instr_valid <= 0, state -> FETCH.
REQ-022 Redirect in HOLD SHALL override stall: next edge pc <= redirect_pc, instr_valid <= 0, state -> FETCH.
REQ-023 Redirect in FETCH with imem_ready=1 SHALL discard imem_rdata: next edge pc <= redirect_pc, state stays FETCH, instr_valid stays 0.
REQ-024 Redirect in FETCH with imem_ready=0 SHALL store redirect_pc in pend_pc and go to FLUSH.
REQ-025 In FLUSH, the outstanding request SHALL be held unchanged (imem_req=1, old imem_addr).
- A further redirect overwrites pend_pc (latest wins).
- On imem_ready=1 the data is discarded; next edge pc <= pend_pc (or the same-cycle redirect_pc if redirect_valid=1), state -> FETCH.
REQ-026 instr_valid SHALL never assert for a word fetched before a redirect.

Reset
REQ-027 rst_n low SHALL, asynchronously, set state=BOOT, pc=RESET_VECTOR, pend_pc=0, imem_req=0, imem_addr=RESET_VECTOR, instr=32'h0000_0013 (NOP), instr_pc=0, instr_valid=0, trap=0.
REQ-028 Reset asserted mid-request SHALL abandon the request; the first post-reset fetch SHALL be at RESET_VECTOR.

Configuration
REQ-029 With FETCH_MISALIGN_TRAP_EN defined, an accepted redirect with redirect_pc[1:0]!=0 SHALL pulse trap for one cycle and use TRAP_VECTOR in place of redirect_pc.
REQ-030 Without FETCH_MISALIGN_TRAP_EN, trap SHALL be tied to 0 and the accepted target SHALL be {redirect_pc[31:2],2'b00}.

Structure
REQ-031 Package fetch_pkg SHALL hold the FSM state enum, the NOP constant 32'h0000_0013 and the PC increment constant 4.
REQ-032 The block SHALL be a single module with no sub-module; the PC register, FSM and output register live in fetch_sequencer.

Verification
REQ-033 Reset release, imem_ready tied 1, stall 0 -> fetch addresses 0, 4, 8 in order, each instr_valid with matching instr_pc.
REQ-034 imem_ready low for 3 cycles in FETCH -> imem_addr held constant for all 3 cycles, with a single capture.
REQ-035 stall=1 for 4 cycles in HOLD -> instr and instr_pc unchanged and no imem_req; redirect_valid=1 with redirect_pc=32'h40 during the stall -> next fetch at 32'h40.
REQ-036 Redirect to 32'h80 while a request at 32'h10 waits, then a second redirect to 32'h90 before imem_ready -> the 32'h10 data is dropped and the next fetch is at 32'h90.
REQ-037 pc=32'hFFFF_FFFC fetch -> next fetch at 32'h0000_0000.
REQ-038 redirect_pc=32'h22 -> macro on: trap pulses once and the fetch is at TRAP_VECTOR; macro off: trap stays 0 and the fetch is at 32'h20.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INCR   = 32'd4;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives single-outstanding requests to instruction
// memory, holds one fetched word for the consumer, and absorbs redirects,
// including redirects that arrive while a request is still waiting for memory.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect target pulses trap and fetches TRAP_VECTOR
//   undefined : trap is tied low and redirect targets are forced word-aligned
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | one idle cycle after reset release, no request
// FETCH | request outstanding at pc, waiting for imem_ready
// HOLD  | fetched word presented on instr, waiting for the consumer
// FLUSH | request abandoned by a redirect but still held until imem_ready;
//       | its data is dropped and pend_pc becomes the next pc
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        trap
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  redir_tgt;
    logic         redir_accept;

    // A redirect is taken in every state except the boot cycle.
    assign redir_accept = redirect_valid && (state_q != BOOT);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic redir_misaligned;
    logic trap_q, trap_d;

    assign redir_misaligned = |redirect_pc[1:0];
    assign redir_tgt        = redir_misaligned ? TRAP_VECTOR : redirect_pc;
    assign trap_d           = redir_accept && redir_misaligned;
    assign trap             = trap_q;

    // Trap pulse register: high for exactly the cycle after a misaligned redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= trap_d;
        end
    end
`else
    // Low address bits and the trap vector are intentionally ignored here.
    logic [33:0] unused_bits;

    assign unused_bits = {TRAP_VECTOR, redirect_pc[1:0]};
    assign redir_tgt   = {redirect_pc[31:2], 2'b00};
    assign trap        = 1'b0;
`endif

    // The request address is always the pc; pc does not move while a request
    // is outstanding, which keeps imem_addr stable through FETCH and FLUSH.
    assign imem_req    = (state_q == FETCH) || (state_q == FLUSH);
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

    // State, pc and output holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            pend_q     <= 32'h0000_0000;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    // Next-state, pc and captured-instruction logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end

            FETCH: begin
                if (redirect_valid) begin
                    if (imem_ready) begin
                        // Returned word belongs to the old path; drop it.
                        pc_d = redir_tgt;
                    end else begin
                        pend_d  = redir_tgt;
                        state_d = FLUSH;
                    end
                end else if (imem_ready) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + PC_INCR;
                    state_d    = HOLD;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_tgt;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end

            FLUSH: begin
                if (redirect_valid) begin
                    pend_d = redir_tgt;
                end
                if (imem_ready) begin
                    pc_d    = redirect_valid ? redir_tgt : pend_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes expected fetch
// addresses and expected presented instructions; a monitor pops and compares.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        trap;

    int total = 0;
    int bad   = 0;
    int trap_cnt = 0;
    logic        vld_prev = 1'b0;
    logic [31:0] fetch_q[$];
    logic [63:0] instr_q[$];

    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [31:0] MIS_TGT       = TRAP_VEC;
    localparam logic        MIS_TRAP      = 1'b1;
    localparam int          EXP_TRAP_CNT  = 1;
`else
    localparam logic [31:0] MIS_TGT       = 32'h0000_0020;
    localparam logic        MIS_TRAP      = 1'b0;
    localparam int          EXP_TRAP_CNT  = 0;
`endif

    fetch_sequencer #(
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR (TRAP_VEC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .trap          (trap)
    );

    always #5 clk = ~clk;

    // Memory model: each word is the inverted address.
    assign imem_rdata = ~imem_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        fetch_q.push_back(a);
    endtask

    task automatic expect_instr(input logic [31:0] pc);
        instr_q.push_back({pc, ~pc});
    endtask

    // Hold imem_ready high until n handshakes have been seen, then drop it
    // just after the edge that completes the last one.
    task automatic run_fetches(input int n);
        int cnt;
        cnt = 0;
        imem_ready = 1'b1;
        for (int c = 0; c < 60 && cnt < n; c++) begin
            @(negedge clk);
            if (imem_req && imem_ready) cnt++;
        end
        if (cnt < n) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout: got %0d handshakes expected %0d", cnt, n);
        end
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
    endtask

    // Monitor: compares every memory handshake and every newly presented instruction.
    always @(negedge clk) begin
        if (!rst_n) begin
            vld_prev <= 1'b0;
        end else begin
            if (imem_req && imem_ready) begin
                if (fetch_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL fetch_unexpected: got addr %h expected no request", imem_addr);
                end else begin
                    check("fetch_addr", imem_addr, fetch_q.pop_front());
                end
            end
            if (instr_valid && !vld_prev) begin
                if (instr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL instr_unexpected: got pc %h expected no instruction", instr_pc);
                end else begin
                    logic [63:0] e;
                    e = instr_q.pop_front();
                    check("instr_pc", instr_pc, e[63:32]);
                    check("instr_data", instr, e[31:0]);
                end
            end
            if (trap) trap_cnt++;
            vld_prev <= instr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        imem_ready     = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        rst_n          = 1'b0;

        step();
        step();
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_trap", {31'b0, trap}, 32'h0);

        // Sequential fetch with memory always ready, no stall.
        imem_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        check("boot_req", {31'b0, imem_req}, 32'h0);
        expect_fetch(32'h0); expect_instr(32'h0);
        expect_fetch(32'h4); expect_instr(32'h4);
        expect_fetch(32'h8); expect_instr(32'h8);
        run_fetches(3);

        // Memory not ready for 3 cycles: address held, one capture.
        step();
        for (int i = 0; i < 3; i++) begin
            check("wait_req", {31'b0, imem_req}, 32'h1);
            check("wait_addr", imem_addr, 32'hC);
            if (i < 2) step();
        end
        stall = 1'b1;
        expect_fetch(32'hC); expect_instr(32'hC);
        run_fetches(1);

        // Stalled HOLD: output stable, no request; then redirect during stall.
        for (int i = 0; i < 4; i++) begin
            check("stall_instr", instr, ~32'hC);
            check("stall_pc", instr_pc, 32'hC);
            check("stall_valid", {31'b0, instr_valid}, 32'h1);
            check("stall_req", {31'b0, imem_req}, 32'h0);
            step();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        expect_fetch(32'h40); expect_instr(32'h40);
        step();
        redirect_valid = 1'b0;
        stall = 1'b0;
        check("hold_redir_req", {31'b0, imem_req}, 32'h1);
        check("hold_redir_addr", imem_addr, 32'h40);
        check("hold_redir_valid", {31'b0, instr_valid}, 32'h0);
        run_fetches(1);

        // Redirect with memory ready in FETCH: returned word discarded.
        step();
        check("fetch44_addr", imem_addr, 32'h44);
        expect_fetch(32'h44);
        imem_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        step();
        imem_ready     = 1'b0;
        redirect_valid = 1'b0;
        check("discard_addr", imem_addr, 32'h10);
        check("discard_valid", {31'b0, instr_valid}, 32'h0);

        // Two redirects while the 0x10 request waits: latest wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        step();
        check("flush_req", {31'b0, imem_req}, 32'h1);
        check("flush_addr", imem_addr, 32'h10);
        redirect_pc = 32'h90;
        step();
        redirect_valid = 1'b0;
        check("flush_addr2", imem_addr, 32'h10);
        expect_fetch(32'h10);
        expect_fetch(32'h90); expect_instr(32'h90);
        run_fetches(2);

        // pc wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        expect_fetch(32'hFFFF_FFFC); expect_instr(32'hFFFF_FFFC);
        expect_fetch(32'h0);         expect_instr(32'h0);
        step();
        redirect_valid = 1'b0;
        run_fetches(2);

        // Misaligned redirect target.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h22;
        expect_fetch(MIS_TGT); expect_instr(MIS_TGT);
        step();
        redirect_valid = 1'b0;
        check("mis_trap", {31'b0, trap}, {31'b0, MIS_TRAP});
        check("mis_addr", imem_addr, MIS_TGT);
        run_fetches(1);

        // Reset in the middle of an outstanding request.
        step();
        step();
        check("midrst_pre_req", {31'b0, imem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_req", {31'b0, imem_req}, 32'h0);
        check("midrst_addr", imem_addr, 32'h0);
        check("midrst_valid", {31'b0, instr_valid}, 32'h0);
        check("midrst_instr", instr, 32'h0000_0013);
        step();
        rst_n = 1'b1;
        expect_fetch(32'h0); expect_instr(32'h0);
        run_fetches(1);

        step();
        step();
        step();
        check("fetch_q_empty", fetch_q.size(), 32'h0);
        check("instr_q_empty", instr_q.size(), 32'h0);
        check("trap_count", trap_cnt, EXP_TRAP_CNT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
